// File: rtl/divider_arbiter.sv
// divider_arbiter: round-robin scheduler sharing one fixed-point divider among NUM_REQ requesters.
// Optional feature: define DIV_ARB_WATCHDOG_EN to abort a WAIT that exceeds TIMEOUT_CYCLES.
module divider_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int N              = 22,
    parameter int Q              = 10,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*N-1:0] req_dividend,
    input  logic [NUM_REQ*N-1:0] req_divisor,
    output logic [NUM_REQ-1:0]   grant,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic [N-1:0]         rsp_q,
    output logic                 rsp_overflow,
    output logic                 rsp_dbz,
    output logic                 rsp_timeout,
    output logic                 div_start,
    output logic [N-1:0]         div_dividend,
    output logic [N-1:0]         div_divisor,
    input  logic                 div_busy,
    input  logic                 div_done,
    input  logic                 div_overflow,
    input  logic                 div_dbz,
    input  logic [N-1:0]         div_q
);
    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    state_t        state, state_n;
    logic [IW-1:0] rr_ptr, winner, pick, idx;
    logic          found, done_ok, wd_expire;
    logic [N-1:0]  sel_dividend, sel_divisor;

    // done is only believed once the divider has dropped busy
    assign done_ok = !div_busy && div_done;

    // Winner is the first requester at or after rr_ptr, wrapping upward
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = IW'((int'(rr_ptr) + k) % NUM_REQ);
            if (req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    // Operand mux for the candidate winner
    always_comb begin
        sel_dividend = '0;
        sel_divisor  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IW'(i) == pick) begin
                sel_dividend = req_dividend[i*N +: N];
                sel_divisor  = req_divisor[i*N +: N];
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = found ? START : IDLE;
            START:   state_n = WAIT;
            WAIT:    state_n = (done_ok || wd_expire) ? RESP : WAIT;
            default: state_n = IDLE;
        endcase
    end

    // Grant/operand latch, start pulse, result capture and pointer advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant        <= '0;
            rsp_valid    <= '0;
            rsp_q        <= '0;
            rsp_overflow <= 1'b0;
            rsp_dbz      <= 1'b0;
            div_start    <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
            rr_ptr       <= '0;
            winner       <= '0;
        end else begin
            div_start <= (state == IDLE) && found;
            rsp_valid <= '0;
            if (state == IDLE && found) begin
                winner       <= pick;
                grant        <= NUM_REQ'(1) << pick;
                div_dividend <= sel_dividend;
                div_divisor  <= sel_divisor;
            end
            if (state == WAIT && (done_ok || wd_expire)) begin
                rsp_valid    <= grant;
                grant        <= '0;
                rsp_q        <= done_ok ? div_q : '0;
                rsp_overflow <= done_ok && div_overflow;
                rsp_dbz      <= done_ok && div_dbz;
            end
            if (state == RESP) rr_ptr <= (winner == IW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
        end
    end

`ifdef DIV_ARB_WATCHDOG_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

    logic [WW-1:0] wd_cnt;

    // A real completion always wins over a same-cycle expiry
    assign wd_expire = (state == WAIT) && !done_ok && (wd_cnt == WW'(TIMEOUT_CYCLES - 1));

    // Watchdog counter runs only in WAIT; timeout flag follows each capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt      <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            wd_cnt <= (state == WAIT) ? wd_cnt + 1'b1 : '0;
            if (state == WAIT && done_ok) rsp_timeout <= 1'b0;
            else if (wd_expire)           rsp_timeout <= 1'b1;
        end
    end
`else
    assign wd_expire   = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

endmodule

// File: doc/divider_arbiter.md
# divider_arbiter

Round-robin scheduler that shares one fixed-point `divider` instance (N-bit two's complement, Q fractional bits) among NUM_REQ requesters. It latches the winning requester's operands, pulses the divider's start, and waits for completion. It then returns quotient, overflow and divide-by-zero flags to that requester with a one-cycle response strobe. It sits between the compute units and the single shared divider.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- N, 22, operand/result width, two's complement
- Q, 10, fractional bits; must match the divider instance
- TIMEOUT_CYCLES, 64, watchdog limit; used only when the watchdog is compiled in
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req  in  NUM_REQ  per-requester request level
- req_dividend  in  NUM_REQ*N  flattened dividends; slice i is bits [i*N +: N]
- req_divisor  in  NUM_REQ*N  flattened divisors; same slicing
- grant  out  NUM_REQ  one-hot; set while requester i owns the divider
- rsp_valid  out  NUM_REQ  one-hot, one-cycle response strobe
- rsp_q  out  N  quotient of the last completed operation
- rsp_overflow  out  1  overflow flag for rsp_q
- rsp_dbz  out  1  divide-by-zero flag for rsp_q
- rsp_timeout  out  1  watchdog abort flag; constant 0 when the watchdog is compiled out
- div_start  out  1  start pulse to the divider
- div_dividend, div_divisor  out  N  registered operands to the divider
- div_busy, div_done, div_overflow, div_dbz  in  1  divider status
- div_q  in  N  divider quotient

## Operation
- Reset values:
  - grant, rsp_valid, div_start, rsp_overflow, rsp_dbz, rsp_timeout = 0.
  - rsp_q, div_dividend, div_divisor = 0.
  - rr_ptr = 0; state = IDLE.
  - Reset mid-operation aborts the operation with no response. The divider is reset by the same rst_n.
- FSM states: IDLE, START, WAIT, RESP.
- IDLE:
  - If any req is set, pick the winner: first index at or after rr_ptr, searching upward with wrap modulo NUM_REQ.
  - Latch that requester's operands into div_dividend/div_divisor, set grant[winner], then go to START.
  - req is sampled only in IDLE.
- START: div_start = 1 for exactly this cycle, then go to WAIT.
- WAIT:
  - Leave when div_busy = 0 and div_done = 1.
  - Capture div_q into rsp_q, and div_overflow/div_dbz into rsp_overflow/rsp_dbz; then go to RESP.
  - div_done is not trusted on the first WAIT cycle. The divider clears it on the edge that samples start, so the exit condition is not met there.
- RESP:
  - rsp_valid[winner] = 1 for one cycle, grant cleared, rr_ptr = (winner+1) mod NUM_REQ, then go to IDLE.
- The arbiter does no arithmetic. Sign handling and abs value live in the divider.
- Requester rules:
  - Hold req and operands until rsp_valid[i].
  - Deassert req in the cycle after rsp_valid[i]; a req still high there is treated as a new request.
  - A requester that drops req while granted still receives its rsp_valid. The arbiter never cancels an in-flight divide.
- rsp_q and the flags hold until the next capture. Requesters read them only when their rsp_valid bit is set.

## Timing
- Let T be the IDLE cycle that samples req.
  - T+1: START.
  - T+1+(N+Q+2): first cycle with div_done high.
  - One cycle later: RESP.
  - Total is N+Q+4 cycles from T to rsp_valid: 36 cycles for the defaults.
- Back-to-back operation: the next grant is decided in the IDLE cycle right after RESP, so there is one idle cycle between operations.
- Simultaneous requests are resolved by rr_ptr only. No requester waits more than NUM_REQ operations.

## Configuration
- DIV_ARB_WATCHDOG_EN defined:
  - A counter runs in WAIT. If it reaches TIMEOUT_CYCLES without exit, the FSM goes to RESP with rsp_timeout = 1, rsp_q = 0, and rsp_overflow = rsp_dbz = 0.
  - rsp_timeout is cleared on the next normal capture.
- DIV_ARB_WATCHDOG_EN undefined: no counter; WAIT waits indefinitely; rsp_timeout tied to 0.

## Test plan
- Positive divide: req[0] with 3.0 / 1.5 (3072 / 1536) -> rsp_valid[0] at T+36; rsp_q = 2048; overflow = dbz = 0.
- Negative divide: req[1] with -3.0 / 1.5 (22-bit 0x3FF400 / 1536) -> rsp_q = -2048 (0x3FF800); flags 0.
- Divide by zero: req[2] with 1.0 / 0 -> rsp_valid[2]; rsp_dbz = 1.
- Overflow: req[3] with 1000.0 / 0.0009765625 (1024000 / 1) -> rsp_overflow = 1.
- Fairness: req[0], req[2] and req[3] raised together from reset -> service order 0, 2, 3. req[0] re-raised during req[2]'s service -> served after 3.
- Watchdog (macro defined): stubbed divider never asserts div_done -> rsp_valid with rsp_timeout = 1 exactly TIMEOUT_CYCLES cycles after WAIT entry. A later normal request returns rsp_timeout = 0.
